// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encode/decode path.
package imm_enc_pkg;

  // Instruction format selector, shared with the decode side.
  typedef enum logic [2:0] {
    IT_I   = 3'd0,
    IT_U   = 3'd1,
    IT_S   = 3'd2,
    IT_R   = 3'd3,
    IT_SB  = 3'd4,
    IT_UJ  = 3'd5,
    IT_LI  = 3'd6,
    IT_RSV = 3'd7
  } imm_type_e;

  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_IMM32 = 7'h1B;
  localparam logic [6:0] OP_LUI   = 7'h37;

  // True when value is representable as a width-bit two's complement number:
  // every bit from width-1 upward must equal the sign bit.
  function automatic logic fits_signed(input logic [63:0] value, input int unsigned width);
    logic [63:0] upper;
    upper = $signed(value) >>> (width - 1);
    return (upper == '0) || (upper == '1);
  endfunction

endpackage

// File: rtl/imm_field_packer.sv
// Combinational field packer: one format + fields + immediate -> 32-bit word.
// Out-of-range immediates and unsupported formats yield err=1, instr=0.
module imm_field_packer
  import imm_enc_pkg::*;
(
  input  imm_type_e   typ,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [63:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  // Format-dependent bit placement plus range check.
  always_comb begin
    instr = '0;
    err   = 1'b0;
    unique case (typ)
      IT_I: begin
        err   = !fits_signed(imm, 12);
        instr = {imm[11:0], rs1, funct3, rd, opcode};
      end
      IT_S: begin
        err   = !fits_signed(imm, 12);
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      IT_U: begin
        err   = (imm[63:32] != '0) || (imm[11:0] != '0);
        instr = {imm[31:12], rd, opcode};
      end
      IT_R: begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      // imm is a halfword offset here, so bit n of imm is byte-offset bit n+1.
      IT_SB: begin
        err   = !fits_signed(imm, 12);
        instr = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
      end
      IT_UJ: begin
        err   = !fits_signed(imm, 20);
        instr = {imm[19], imm[9:0], imm[10], imm[18:11], rd, opcode};
      end
      default: begin
        // LI is expanded upstream; reaching here with LI or reserved is an error.
        err = 1'b1;
      end
    endcase
    if (err) instr = '0;
  end

endmodule

// File: rtl/imm_encoder.sv
// Instruction encoder with LI pseudo-op expansion and a single registered
// output word. LI may produce LUI followed by ADDIW; the ADDIW is packed
// from captured rd/lo while the LUI is held, so the packer is shared.
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter bit LI_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_type,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);

  typedef enum logic [1:0] {S_IDLE, S_OUT, S_OUT_HI} state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [4:0]  rd_q, rd_d;
  logic [11:0] lo_q, lo_d;

  logic        accept;
  logic        is_li, li_fit32, li_fit12, li_pair, li_bad;
  logic [31:0] li_sum;

  imm_type_e   pk_type;
  logic [6:0]  pk_op;
  logic [2:0]  pk_f3;
  logic [4:0]  pk_rd, pk_rs1;
  logic [63:0] pk_imm;
  logic [31:0] pk_instr;
  logic        pk_err;

  assign in_ready = !reset && ((state_q == S_IDLE) || ((state_q == S_OUT) && out_ready));
  assign accept   = in_valid && in_ready;

  assign is_li    = LI_EN && (in_type == 3'(IT_LI));
  assign li_fit32 = fits_signed(in_imm, 32);
  assign li_fit12 = fits_signed(in_imm, 12);
  // Rounding the upper part by +0x800 compensates for ADDIW sign-extending lo.
  assign li_sum   = in_imm[31:0] + 32'h0000_0800;
  assign li_pair  = is_li && li_fit32 && !li_fit12 && (in_imm[11:0] != '0);
  assign li_bad   = is_li && !li_fit32;

  // Packer input select: pending ADDIW, LI first word, or the raw request.
  always_comb begin
    pk_type = imm_type_e'(in_type);
    pk_op   = in_opcode;
    pk_f3   = in_funct3;
    pk_rd   = in_rd;
    pk_rs1  = in_rs1;
    pk_imm  = in_imm;
    if (state_q == S_OUT_HI) begin
      pk_type = IT_I;
      pk_op   = OP_IMM32;
      pk_f3   = 3'd0;
      pk_rd   = rd_q;
      pk_rs1  = rd_q;
      pk_imm  = {{52{lo_q[11]}}, lo_q};
    end else if (is_li) begin
      pk_f3  = 3'd0;
      pk_rs1 = 5'd0;
      if (li_fit12) begin
        pk_type = IT_I;
        pk_op   = OP_IMM;
      end else begin
        pk_type = IT_U;
        pk_op   = OP_LUI;
        pk_imm  = {32'd0, li_sum[31:12], 12'd0};
      end
    end
  end

  imm_field_packer u_packer (
    .typ    (pk_type),
    .opcode (pk_op),
    .funct3 (pk_f3),
    .funct7 (in_funct7),
    .rd     (pk_rd),
    .rs1    (pk_rs1),
    .rs2    (in_rs2),
    .imm    (pk_imm),
    .instr  (pk_instr),
    .err    (pk_err)
  );

  // Next-state: load on accept, advance LUI->ADDIW, retire on consume.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    last_d  = last_q;
    err_d   = err_q;
    rd_d    = rd_q;
    lo_d    = lo_q;
    if (state_q == S_OUT_HI) begin
      if (out_ready) begin
        state_d = S_OUT;
        instr_d = pk_instr;
        last_d  = 1'b1;
        err_d   = 1'b0;
      end
    end else if (accept) begin
      err_d   = pk_err || li_bad;
      instr_d = (pk_err || li_bad) ? 32'd0 : pk_instr;
      last_d  = !li_pair;
      state_d = li_pair ? S_OUT_HI : S_OUT;
      rd_d    = in_rd;
      lo_d    = in_imm[11:0];
    end else if ((state_q == S_OUT) && out_ready) begin
      state_d = S_IDLE;
    end
  end

  // State and output register; sync reset drops any pending ADDIW.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      lo_q    <= lo_d;
    end
  end

  assign out_valid = (state_q != S_IDLE);
  assign out_instr = instr_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed cases plus randomized requests
// against an ISA-level reference model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        out_err;

  imm_encoder #(.LI_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_last(out_last), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  typ;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic        last;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   rand_bp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model (ISA-level) ----------------
  function automatic bit fits(input longint v, input int w);
    longint lim;
    lim = longint'(1) << (w - 1);
    return (v >= -lim) && (v < lim);
  endfunction

  function automatic logic [31:0] w32(input longint unsigned v);
    return v[31:0];
  endfunction

  function automatic void push_w(input logic [31:0] instr, input bit last, input bit err);
    exp_t e;
    e.instr = instr; e.last = last; e.err = err;
    sb.push_back(e);
  endfunction

  function automatic void model(input req_t r);
    longint          v;
    longint unsigned op, rd, rs1, rs2, f3, f7, u, b;
    longint          lo, hi;
    v = longint'(r.imm); u = r.imm;
    op = 64'(r.op); rd = 64'(r.rd); rs1 = 64'(r.rs1); rs2 = 64'(r.rs2);
    f3 = 64'(r.f3); f7 = 64'(r.f7);
    case (r.typ)
      3'd0: if (fits(v, 12)) push_w(w32(((u & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op), 1, 0);
            else push_w(0, 1, 1);
      3'd1: if ((u >> 32) == 0 && (u & 'hFFF) == 0) push_w(w32(u | (rd << 7) | op), 1, 0);
            else push_w(0, 1, 1);
      3'd2: if (fits(v, 12)) push_w(w32((((u >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((u & 'h1F) << 7) | op), 1, 0);
            else push_w(0, 1, 1);
      3'd3: push_w(w32((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op), 1, 0);
      3'd4: if (fits(v, 12)) begin
              b = u * 2;  // byte offset, standard B-format scatter
              push_w(w32((((b >> 12) & 1) << 31) | (((b >> 5) & 'h3F) << 25) | (rs2 << 20) | (rs1 << 15) |
                         (f3 << 12) | (((b >> 1) & 'hF) << 8) | (((b >> 11) & 1) << 7) | op), 1, 0);
            end else push_w(0, 1, 1);
      3'd5: if (fits(v, 20)) begin
              b = u * 2;  // byte offset, standard J-format scatter
              push_w(w32((((b >> 20) & 1) << 31) | (((b >> 1) & 'h3FF) << 21) | (((b >> 11) & 1) << 20) |
                         (((b >> 12) & 'hFF) << 12) | (rd << 7) | op), 1, 0);
            end else push_w(0, 1, 1);
      3'd6: if (!fits(v, 32)) push_w(0, 1, 1);
            else if (fits(v, 12)) push_w(w32(((u & 'hFFF) << 20) | (rd << 7) | 'h13), 1, 0);
            else begin
              lo = (v & 'hFFF) >= 'h800 ? (v & 'hFFF) - 'h1000 : (v & 'hFFF);
              hi = ((v - lo) >>> 12) & 'hFFFFF;
              if (lo == 0) push_w(w32((longint'(hi) << 12) | (rd << 7) | 'h37), 1, 0);
              else begin
                push_w(w32((longint'(hi) << 12) | (rd << 7) | 'h37), 0, 0);
                push_w(w32(((longint'(lo) & 'hFFF) << 20) | (rd << 15) | (rd << 7) | 'h1B), 1, 0);
              end
            end
      default: push_w(0, 1, 1);
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic send(input req_t r, input bit use_model);
    int n;
    in_type = r.typ; in_opcode = r.op; in_funct3 = r.f3; in_funct7 = r.f7;
    in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2; in_imm = r.imm;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        if (use_model) model(r);
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 200) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  function automatic req_t mk(input logic [2:0] t, input logic [6:0] op, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [63:0] imm);
    req_t r;
    r.typ = t; r.op = op; r.f3 = f3; r.f7 = 7'h20; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
    return r;
  endfunction

  function automatic logic [63:0] rnd_imm();
    logic [63:0] edges [12];
    logic [31:0] r32;
    edges = '{64'd2047, -64'sd2048, 64'd2048, -64'sd2049, 64'd524287, -64'sd524288,
              64'd524288, 64'h7FFF_FFFF, 64'h7FFF_F800, 64'hFFFF_FFFF_8000_0000,
              64'h8000_0000, 64'h1234_5000};
    r32 = $urandom;
    case ($urandom_range(0, 5))
      0: return 64'($signed(13'($urandom_range(0, 8191))));
      1: return edges[$urandom_range(0, 11)];
      2: return {{32{r32[31]}}, r32};
      3: return {32'd0, r32[31:12], 12'd0};
      4: return {r32, 32'($urandom)};
      default: return 64'($signed(21'($urandom)));
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      pop_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_word", {32'd0, out_instr}, 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("instr", {32'd0, out_instr}, {32'd0, e.instr});
        chk("last", {63'd0, out_last}, {63'd0, e.last});
        chk("err", {63'd0, out_err}, {63'd0, e.err});
      end
    end
  end

  // Random backpressure, applied just after each rising edge.
  initial forever begin
    @(posedge clk); #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic drain();
    int n;
    rand_bp = 0; out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 500) begin @(posedge clk); n++; end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    req_t r;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_type = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 0);
    chk("rst_out_instr", {32'd0, out_instr}, 0);
    chk("rst_out_last", {63'd0, out_last}, 0);
    chk("rst_out_err", {63'd0, out_err}, 0);
    chk("rst_in_ready", {63'd0, in_ready}, 0);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;

    // Directed encodings with hand-derived constants.
    push_w(32'hFFF30293, 1, 0);
    send(mk(3'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF), 0);
    push_w(32'hFE208EE3, 1, 0);
    send(mk(3'd4, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE), 0);
    push_w(32'h7FF00093, 1, 0);
    send(mk(3'd6, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 64'h7FF), 0);
    push_w(32'h800000B7, 0, 0);
    push_w(32'hFFF0809B, 1, 0);
    send(mk(3'd6, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 64'h7FFF_FFFF), 0);
    drain();

    // LI with each word held under backpressure.
    out_ready = 1'b0;
    push_w(32'h12345537, 0, 0);
    push_w(32'h6785051B, 1, 0);
    send(mk(3'd6, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 64'h1234_5678), 0);
    in_imm = 64'h5555;  // post-accept input change must not matter
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_hi_valid", {63'd0, out_valid}, 1);
      chk("hold_hi_instr", {32'd0, out_instr}, 64'h12345537);
      chk("hold_hi_last", {63'd0, out_last}, 0);
      chk("hold_hi_in_ready", {63'd0, in_ready}, 0);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_lo_instr", {32'd0, out_instr}, 64'h6785051B);
      chk("hold_lo_last", {63'd0, out_last}, 1);
      chk("hold_lo_in_ready", {63'd0, in_ready}, 0);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    drain();

    // Error cases, then recovery.
    push_w(0, 1, 1);
    send(mk(3'd1, 7'h37, 3'd0, 5'd3, 5'd0, 5'd0, 64'h1001), 0);
    push_w(0, 1, 1);
    send(mk(3'd0, 7'h13, 3'd0, 5'd3, 5'd4, 5'd0, 64'h800), 0);
    push_w(0, 1, 1);
    send(mk(3'd7, 7'h13, 3'd0, 5'd3, 5'd4, 5'd0, 64'h0), 0);
    push_w(32'hFFF30293, 1, 0);
    send(mk(3'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF), 0);
    drain();

    // Reset while the ADDIW is pending.
    out_ready = 1'b0;
    send(mk(3'd6, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 64'h1234_5678), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", {63'd0, in_ready}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst_mid_out_valid", {63'd0, out_valid}, 0);
    chk("rst_mid_in_ready_after", {63'd0, in_ready}, 1);
    @(posedge clk); #1;

    // Back-to-back stream: one word per cycle.
    out_ready = 1'b1;
    pop_cyc.delete();
    for (int i = 0; i < 4; i++)
      send(mk(3'd0, 7'h13, 3'(i), 5'(i + 1), 5'(i + 7), 5'd0, 64'(i * 100)), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("stream_count", 64'(pop_cyc.size()), 4);
    if (pop_cyc.size() >= 4) chk("stream_span", 64'(pop_cyc[3] - pop_cyc[0]), 3);
    drain();

    // Randomized traffic under random backpressure.
    rand_bp = 1;
    for (int i = 0; i < 300; i++) begin
      r.typ = 3'($urandom_range(0, 7));
      r.op = 7'($urandom); r.f3 = 3'($urandom); r.f7 = 7'($urandom);
      r.rd = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
      r.imm = rnd_imm();
      send(r, 1);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
